// File: rtl/mcu_tx_arbiter.sv
// Round-robin, handshaked arbiter sharing the 24-bit MCU command TX FIFO, with locked bursts.
// Optional idle NOPE filler frames are enabled by defining MCU_TX_NOPE_FILL_EN.
module mcu_tx_arbiter #(
  parameter int          N_REQ        = 4,
  parameter logic [23:0] NOPE_FRAME   = 24'hFF0000,
  parameter int          LOCK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  input  logic [N_REQ*24-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               inhibit,
  input  logic               queue_full,
  input  logic               queue_afull,
  input  logic               queue_empty,
  output logic               queue_wr_req,
  output logic [23:0]        queue_di,
  output logic [2:0]         grant_idx,
  output logic               locked
);

  typedef enum logic {ARB, BURST} state_e;

  localparam logic [7:0] TMO_LIM = 8'(LOCK_TIMEOUT);

  state_e      state_q, state_d;
  logic [2:0]  owner_q, owner_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        wr_q, wr_d;
  logic [23:0] di_q, di_d;
  logic [2:0]  grant_q, grant_d;

  logic        space;
  logic        found;
  logic [2:0]  sel;
  logic        owner_valid;
  logic        sel_last;
  logic [23:0] sel_frame;
  logic [3:0]  cand;
  logic        accept;

  function automatic logic [2:0] next_ptr(input logic [2:0] v);
    return (v == 3'(N_REQ - 1)) ? 3'd0 : v + 3'd1;
  endfunction

  // An almost-full FIFO can still take the frame in flight but nothing after it.
  assign space = ~queue_full & ~(queue_afull & wr_q);

  // Requester selection; only req_valid and FIFO status reach req_ready, never req_data.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    found       = 1'b0;
    sel         = 3'd0;
    owner_valid = 1'b0;
    sel_last    = 1'b0;
    sel_frame   = '0;
    cand        = 4'd0;
    req_ready   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (3'(i) == owner_q) owner_valid = req_valid[i];
    end
    if (state_q == ARB) begin
      if (space && !inhibit) begin
        for (int k = 0; k < N_REQ; k++) begin
          cand = {1'b0, rr_ptr_q} + 4'(k);
          if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
          for (int i = 0; i < N_REQ; i++) begin
            if (!found && (4'(i) == cand) && req_valid[i]) begin
              found = 1'b1;
              sel   = 3'(i);
            end
          end
        end
      end
    end else begin
      found = space && owner_valid;
      sel   = owner_q;
    end
    if (reset) found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = found && (sel == 3'(i));
      if (sel == 3'(i)) begin
        sel_last  = req_last[i];
        sel_frame = req_data[24*i +: 24];
      end
    end
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    tmo_cnt_d = tmo_cnt_q;
    wr_d      = 1'b0;
    di_d      = di_q;
    grant_d   = grant_q;
    if (accept) begin
      wr_d      = 1'b1;
      di_d      = sel_frame;
      grant_d   = sel;
      tmo_cnt_d = 8'd0;
      if (sel_last) begin
        rr_ptr_d = next_ptr(sel);
        state_d  = ARB;
      end else begin
        owner_d = sel;
        state_d = BURST;
      end
    end else if (state_q == BURST) begin
      // A stalled owner releases the lock after TMO_LIM idle cycles; a valid-but-blocked owner does not count.
      if (owner_valid) begin
        tmo_cnt_d = 8'd0;
      end else if (tmo_cnt_q + 8'd1 == TMO_LIM) begin
        tmo_cnt_d = 8'd0;
        rr_ptr_d  = next_ptr(owner_q);
        state_d   = ARB;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
      end
    end
`ifdef MCU_TX_NOPE_FILL_EN
    else if ((req_valid == '0) && queue_empty && !wr_q) begin
      wr_d = 1'b1;
      di_d = NOPE_FRAME;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB;
      owner_q   <= 3'd0;
      rr_ptr_q  <= 3'd0;
      tmo_cnt_q <= 8'd0;
      wr_q      <= 1'b0;
      di_q      <= 24'd0;
      grant_q   <= 3'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
      wr_q      <= wr_d;
      di_q      <= di_d;
      grant_q   <= grant_d;
    end
  end

  assign queue_wr_req = wr_q;
  assign queue_di     = di_q;
  assign grant_idx    = grant_q;
  assign locked       = (state_q == BURST);

endmodule

// File: tb/tb_mcu_tx_arbiter.sv
// Directed self-checking bench for mcu_tx_arbiter (N_REQ=4, LOCK_TIMEOUT=8).
// Build with MCU_TX_NOPE_FILL_EN defined to exercise the NOPE filler.
module tb_mcu_tx_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_last;
  logic [N*24-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          inhibit;
  logic          queue_full;
  logic          queue_afull;
  logic          queue_empty;
  logic          queue_wr_req;
  logic [23:0]   queue_di;
  logic [2:0]    grant_idx;
  logic          locked;

  int checks = 0;
  int errors = 0;

  mcu_tx_arbiter #(.N_REQ(N), .NOPE_FRAME(24'hFF0000), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .inhibit(inhibit), .queue_full(queue_full), .queue_afull(queue_afull), .queue_empty(queue_empty),
    .queue_wr_req(queue_wr_req), .queue_di(queue_di), .grant_idx(grant_idx), .locked(locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [23:0] v);
    req_data[24*i +: 24] = v;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    inhibit = 1'b0; queue_full = 1'b0; queue_afull = 1'b0; queue_empty = 1'b0;
    #3;
    checks++;
    if (queue_wr_req !== 1'b0 || queue_di !== 24'd0 || grant_idx !== 3'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%b di=%h grant=%0d locked=%b, want all zero",
               queue_wr_req, queue_di, grant_idx, locked);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++;
    if (req_ready !== 4'b0000 || queue_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got ready=%b wr=%b, want 0000/0", req_ready, queue_wr_req);
    end
  endtask

  task automatic test_fairness();
    for (int i = 0; i < N; i++) set_data(i, 24'hC00000 | 24'(i * 24'h000101));
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'(1 << (c % 4))) begin
        errors++;
        $display("FAIL fair_ready[%0d]: got %b want %b", c, req_ready, 4'(1 << (c % 4)));
      end
      tick();
      checks++;
      if (queue_wr_req !== 1'b1 || grant_idx !== 3'(c % 4) ||
          queue_di !== (24'hC00000 | 24'((c % 4) * 24'h000101)) || locked !== 1'b0) begin
        errors++;
        $display("FAIL fair_write[%0d]: got wr=%b grant=%0d di=%h locked=%b want 1/%0d/%h/0",
                 c, queue_wr_req, grant_idx, queue_di, locked, c % 4,
                 24'hC00000 | 24'((c % 4) * 24'h000101));
      end
    end
    req_valid = '0;
    tick();
    checks++;
    if (queue_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL fair_quiet: got wr=%b want 0", queue_wr_req);
    end
  endtask

  task automatic test_burst_lock();
    logic [23:0] frames [4];
    frames[0] = 24'hF90011; frames[1] = 24'hF90122; frames[2] = 24'hF90233; frames[3] = 24'hF90344;
    // Move the pointer to 2 with a single frame from requester 1.
    req_valid = 4'b0010; req_last = 4'b1111; set_data(1, 24'h111111);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL burst_pre_ready: got %b want 0010", req_ready);
    end
    tick();
    req_valid = 4'b0111;
    set_data(0, 24'h000A0A);
    for (int f = 0; f < 4; f++) begin
      set_data(2, frames[f]);
      req_last = (f == 3) ? 4'b1111 : 4'b1011;
      inhibit  = (f >= 1);
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
        errors++;
        $display("FAIL burst_ready[%0d]: got %b want 0100", f, req_ready);
      end
      tick();
      checks++;
      if (queue_wr_req !== 1'b1 || queue_di !== frames[f] || grant_idx !== 3'd2 || locked !== (f < 3)) begin
        errors++;
        $display("FAIL burst_frame[%0d]: got wr=%b di=%h grant=%0d locked=%b want 1/%h/2/%b",
                 f, queue_wr_req, queue_di, grant_idx, locked, frames[f], (f < 3));
      end
    end
    inhibit = 1'b0;
    req_valid = 4'b1011;
    set_data(3, 24'h333333);
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL burst_resume3: got %b want 1000", req_ready);
    end
    tick();
    checks++;
    if (grant_idx !== 3'd3 || queue_di !== 24'h333333) begin
      errors++;
      $display("FAIL burst_grant3: got grant=%0d di=%h want 3/333333", grant_idx, queue_di);
    end
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL burst_resume0: got %b want 0001", req_ready);
    end
    tick();
    checks++;
    if (grant_idx !== 3'd0 || queue_di !== 24'h000A0A) begin
      errors++;
      $display("FAIL burst_grant0: got grant=%0d di=%h want 0/000a0a", grant_idx, queue_di);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    // Pointer is now 1.
    req_valid = 4'b0010; req_last = 4'b1111; set_data(1, 24'h123456);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_first_ready: got %b want 0010", req_ready);
    end
    tick();
    queue_afull = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || queue_wr_req !== 1'b1) begin
      errors++;
      $display("FAIL bp_afull_ready: got ready=%b wr=%b want 0000/1", req_ready, queue_wr_req);
    end
    tick();
    checks++;
    if (queue_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL bp_afull_write: got wr=%b want 0", queue_wr_req);
    end
    queue_afull = 1'b0;
    queue_full  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_full_ready[%0d]: got %b want 0000", c, req_ready);
      end
      tick();
      checks++;
      if (queue_wr_req !== 1'b0) begin
        errors++;
        $display("FAIL bp_full_write[%0d]: got wr=%b want 0", c, queue_wr_req);
      end
    end
    queue_full = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_resume_ready: got %b want 0010", req_ready);
    end
    tick();
    checks++;
    if (queue_wr_req !== 1'b1 || grant_idx !== 3'd1 || queue_di !== 24'h123456) begin
      errors++;
      $display("FAIL bp_resume_write: got wr=%b grant=%0d di=%h want 1/1/123456",
               queue_wr_req, grant_idx, queue_di);
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    // Pointer is now 2; requester 2 opens a burst and then stalls.
    req_valid = 4'b0100; req_last = 4'b1011;
    for (int f = 0; f < 2; f++) begin
      set_data(2, 24'hAA0001 + 24'(f));
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
        errors++;
        $display("FAIL tmo_burst_ready[%0d]: got %b want 0100", f, req_ready);
      end
      tick();
    end
    checks++;
    if (locked !== 1'b1 || grant_idx !== 3'd2 || queue_di !== 24'hAA0002) begin
      errors++;
      $display("FAIL tmo_locked: got locked=%b grant=%0d di=%h want 1/2/aa0002", locked, grant_idx, queue_di);
    end
    req_valid = 4'b1000; req_last = 4'b1111; set_data(3, 24'h3C3C3C);
    for (int t = 1; t <= 8; t++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL tmo_idle_ready[%0d]: got %b want 0000", t, req_ready);
      end
      tick();
      checks++;
      if (queue_wr_req !== 1'b0 || locked !== (t < 8)) begin
        errors++;
        $display("FAIL tmo_idle[%0d]: got wr=%b locked=%b want 0/%b", t, queue_wr_req, locked, (t < 8));
      end
    end
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL tmo_regrant_ready: got %b want 1000", req_ready);
    end
    tick();
    checks++;
    if (queue_wr_req !== 1'b1 || grant_idx !== 3'd3 || queue_di !== 24'h3C3C3C) begin
      errors++;
      $display("FAIL tmo_regrant: got wr=%b grant=%0d di=%h want 1/3/3c3c3c", queue_wr_req, grant_idx, queue_di);
    end
    req_valid = '0;
  endtask

  task automatic test_nope();
    logic exp_wr;
    queue_empty = 1'b1;
    inhibit     = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
`ifdef MCU_TX_NOPE_FILL_EN
      exp_wr = (t % 2 == 0);
`else
      exp_wr = 1'b0;
`endif
      checks++;
      if (queue_wr_req !== exp_wr) begin
        errors++;
        $display("FAIL nope_strobe[%0d]: got wr=%b want %b", t, queue_wr_req, exp_wr);
      end
      if (exp_wr) begin
        checks++;
        if (queue_di !== 24'hFF0000 || grant_idx !== 3'd3) begin
          errors++;
          $display("FAIL nope_frame[%0d]: got di=%h grant=%0d want ff0000/3", t, queue_di, grant_idx);
        end
      end
    end
    queue_empty = 1'b0;
    inhibit     = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    // Pointer is now 0; requester 3 opens a burst.
    req_valid = 4'b1000; req_last = 4'b0111;
    for (int f = 0; f < 2; f++) begin
      set_data(3, 24'hBB0001 + 24'(f));
      #1;
      tick();
    end
    checks++;
    if (locked !== 1'b1 || grant_idx !== 3'd3 || queue_di !== 24'hBB0002) begin
      errors++;
      $display("FAIL rst_pre: got locked=%b grant=%0d di=%h want 1/3/bb0002", locked, grant_idx, queue_di);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (queue_wr_req !== 1'b0 || queue_di !== 24'd0 || grant_idx !== 3'd0 || locked !== 1'b0 ||
        req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_async: got wr=%b di=%h grant=%0d locked=%b ready=%b want all zero",
               queue_wr_req, queue_di, grant_idx, locked, req_ready);
    end
    #2;
    reset = 1'b0;
    req_valid = 4'b1010; req_last = 4'b1111; set_data(1, 24'h0F0F0F);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rst_regrant_ready: got %b want 0010", req_ready);
    end
    tick();
    checks++;
    if (queue_wr_req !== 1'b1 || grant_idx !== 3'd1 || queue_di !== 24'h0F0F0F || locked !== 1'b0) begin
      errors++;
      $display("FAIL rst_regrant: got wr=%b grant=%0d di=%h locked=%b want 1/1/0f0f0f/0",
               queue_wr_req, grant_idx, queue_di, locked);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_burst_lock();
    test_backpressure();
    test_timeout();
    test_nope();
    test_async_reset();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
